// File: rtl/fproc_arbiter_if.sv
// Handshake bundle between the distributed-processor cores, the fproc arbiter and the shared fproc.
// The master view belongs to the arbiter; the slave view is the cores-plus-fproc side.
interface fproc_arbiter_if #(
   parameter int N_CORES    = 4,
   parameter int ID_WIDTH   = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   logic [N_CORES-1:0]          core_req;
   logic [N_CORES*ID_WIDTH-1:0] core_id;
   logic [N_CORES-1:0]          core_ready;
   logic [DATA_WIDTH-1:0]       core_data;
   logic [N_CORES-1:0]          core_timeout;
   logic                        fproc_req;
   logic [ID_WIDTH-1:0]         fproc_id;
   logic [CORE_W-1:0]           fproc_core;
   logic                        fproc_ack;
   logic                        fproc_valid;
   logic [DATA_WIDTH-1:0]       fproc_data;

   modport master (
      input  core_req, core_id, fproc_ack, fproc_valid, fproc_data,
      output core_ready, core_data, core_timeout, fproc_req, fproc_id, fproc_core
   );

   modport slave (
      output core_req, core_id, fproc_ack, fproc_valid, fproc_data,
      input  core_ready, core_data, core_timeout, fproc_req, fproc_id, fproc_core
   );
endinterface

// File: rtl/fproc_arbiter.sv
// Round-robin arbiter sharing one fproc port among N_CORES cores: latches one-cycle requests,
// runs a single transaction at a time and returns the result (or a timeout) as a one-cycle pulse.
module fproc_arbiter #(
   parameter int N_CORES        = 4,
   parameter int ID_WIDTH       = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset,
   fproc_arbiter_if.master bus
);
   localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CORE_W-1:0] LAST_INIT = CORE_W'(N_CORES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_n;
   logic [N_CORES-1:0]    pending, pending_n, pending_clr, id_load;
   logic [ID_WIDTH-1:0]   id_reg [N_CORES];
   logic [CORE_W-1:0]     last_grant, last_grant_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic                  timed_out;

   logic [N_CORES-1:0]    core_ready_q, core_ready_n;
   logic [N_CORES-1:0]    core_timeout_q, core_timeout_n;
   logic [DATA_WIDTH-1:0] core_data_q, core_data_n;
   logic                  fproc_req_q, fproc_req_n;
   logic [ID_WIDTH-1:0]   fproc_id_q, fproc_id_n;
   logic [CORE_W-1:0]     fproc_core_q, fproc_core_n;
   logic [N_CORES-1:0]    grant_onehot;

   logic [CORE_W-1:0]     sel, cand_idx;
   logic                  sel_found;
   int                    cand;

   // A request that arrives while its core is already pending keeps the original id.
   assign id_load      = bus.core_req & ~pending;
   assign pending_n    = (pending & ~pending_clr) | bus.core_req;
   assign timed_out    = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST);
   assign grant_onehot = N_CORES'(1) << fproc_core_q;

   // Search last_grant+1, +2, ... (mod N_CORES) for the first pending core.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= N_CORES; k++) begin
         cand     = (int'(last_grant) + k) % N_CORES;
         cand_idx = CORE_W'(cand);
         if (!sel_found && pending[cand_idx]) begin
            sel       = cand_idx;
            sel_found = 1'b1;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_n        = state;
      last_grant_n   = last_grant;
      cnt_n          = cnt;
      pending_clr    = '0;
      core_ready_n   = '0;
      core_timeout_n = '0;
      core_data_n    = core_data_q;
      fproc_req_n    = 1'b0;
      fproc_id_n     = fproc_id_q;
      fproc_core_n   = fproc_core_q;

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (sel_found) begin
               fproc_core_n = sel;
               fproc_id_n   = id_reg[sel];
               fproc_req_n  = 1'b1;
               state_n      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_n       = cnt + CNT_W'(1);
            fproc_req_n = 1'b1;
            if (timed_out) begin
               fproc_req_n    = 1'b0;
               core_data_n    = '0;
               core_ready_n   = grant_onehot;
               core_timeout_n = grant_onehot;
               state_n        = RESP;
            end else if (bus.fproc_ack) begin
               fproc_req_n = 1'b0;
               state_n     = WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt + CNT_W'(1);
            if (bus.fproc_valid) begin
               core_data_n  = bus.fproc_data;
               core_ready_n = grant_onehot;
               state_n      = RESP;
            end else if (timed_out) begin
               core_data_n    = '0;
               core_ready_n   = grant_onehot;
               core_timeout_n = grant_onehot;
               state_n        = RESP;
            end
         end
         RESP: begin
            pending_clr  = grant_onehot;
            last_grant_n = fproc_core_q;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         pending        <= '0;
         last_grant     <= LAST_INIT;
         cnt            <= '0;
         core_ready_q   <= '0;
         core_timeout_q <= '0;
         core_data_q    <= '0;
         fproc_req_q    <= 1'b0;
         fproc_id_q     <= '0;
         fproc_core_q   <= '0;
      end else begin
         state          <= state_n;
         pending        <= pending_n;
         last_grant     <= last_grant_n;
         cnt            <= cnt_n;
         core_ready_q   <= core_ready_n;
         core_timeout_q <= core_timeout_n;
         core_data_q    <= core_data_n;
         fproc_req_q    <= fproc_req_n;
         fproc_id_q     <= fproc_id_n;
         fproc_core_q   <= fproc_core_n;
      end
   end

   // NOTE: the id registers are small and reset to 0 so a reset leaves no stale id visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CORES; i++) begin
         if (reset)
            id_reg[i] <= '0;
         else if (id_load[i])
            id_reg[i] <= bus.core_id[i*ID_WIDTH +: ID_WIDTH];
      end
   end

   assign bus.core_ready   = core_ready_q;
   assign bus.core_timeout = core_timeout_q;
   assign bus.core_data    = core_data_q;
   assign bus.fproc_req    = fproc_req_q;
   assign bus.fproc_id     = fproc_id_q;
   assign bus.fproc_core   = fproc_core_q;
endmodule
